// File: rtl/interleaver_pingpong_ctrl_if.sv
// Handshake and RAM-port bundle for the ping-pong interleaver controller.
// The flush signal exists only when INTLV_FLUSH_EN is defined.
interface interleaver_pingpong_ctrl_if #(
    parameter int AW = 8
);
    logic          data_in;
    logic          valid_in;
    logic          ready_out;
    logic          ram_wren;
    logic [AW:0]   ram_wraddr;
    logic          ram_wdata;
    logic          ram_rden;
    logic [AW:0]   ram_rdaddr;
    logic          ram_q;
    logic          data_out;
    logic          valid_out;
    logic          ready_in;
    logic          block_start;
`ifdef INTLV_FLUSH_EN
    logic          flush;
`endif

    // Both sides use strict valid/ready: a transfer happens on a clock edge
    // where valid and ready are both high; valid never waits for ready.
    modport master (
`ifdef INTLV_FLUSH_EN
        input  flush,
`endif
        input  data_in, valid_in, ram_q, ready_in,
        output ready_out, ram_wren, ram_wraddr, ram_wdata,
        output ram_rden, ram_rdaddr, data_out, valid_out, block_start
    );

    modport slave (
`ifdef INTLV_FLUSH_EN
        output flush,
`endif
        output data_in, valid_in, ram_q, ready_in,
        input  ready_out, ram_wren, ram_wraddr, ram_wdata,
        input  ram_rden, ram_rdaddr, data_out, valid_out, block_start
    );
endinterface

// File: rtl/interleaver_pingpong_ctrl.sv
// Two-bank WiMAX block interleaver sequencer: permuted writes into one bank,
// sequential reads from the other. Optional flush input under INTLV_FLUSH_EN.
module interleaver_pingpong_ctrl #(
    parameter int Ncbps = 192,
    parameter int Ncpc  = 2,
    parameter int d     = 16
) (
    input  logic clk,
    input  logic reset,
    interleaver_pingpong_ctrl_if.master bus
);
    localparam int AW   = $clog2(Ncbps);
    localparam int ROWS = Ncbps / d;
    localparam int S    = Ncpc / 2;
    localparam int CW   = (d > 1) ? $clog2(d) : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [AW-1:0] rd_idx_q, rd_idx_d;
    logic [1:0]    full_q, full_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic          valid_out_q, valid_out_d;
    logic          block_start_q, block_start_d;

    logic [AW-1:0] mk;
    logic [AW-1:0] jk;
    logic          flush_now;
    logic          wr_fire;
    logic          wr_last;
    logic          rd_last;

`ifdef INTLV_FLUSH_EN
    assign flush_now = bus.flush;
`else
    assign flush_now = 1'b0;
`endif

    // First permutation from the column/row counters; the second one only
    // touches the LSB when s = 2 because Ncbps is even.
    assign mk = AW'(ROWS) * AW'(col_q) + AW'(row_q);

    if (S == 2) begin : g_s2
        assign jk = {mk[AW-1:1], mk[0] ^ col_q[0]};
    end else begin : g_s1
        assign jk = mk;
    end

    assign bus.ready_out   = !reset && !full_q[wr_bank_q];
    assign wr_fire         = bus.valid_in && bus.ready_out && !flush_now;
    assign wr_last         = (col_q == CW'(d - 1)) && (row_q == RW'(ROWS - 1));
    assign bus.ram_wren    = wr_fire;
    assign bus.ram_wraddr  = {wr_bank_q, jk};
    assign bus.ram_wdata   = bus.data_in;

    assign bus.ram_rden    = !reset && full_q[rd_bank_q] && (!valid_out_q || bus.ready_in);
    assign rd_last         = (rd_idx_q == AW'(Ncbps - 1));
    assign bus.ram_rdaddr  = {rd_bank_q, rd_idx_q};
    assign bus.data_out    = bus.ram_q;
    assign bus.valid_out   = valid_out_q;
    assign bus.block_start = block_start_q;

    always_comb begin
        col_d         = col_q;
        row_d         = row_q;
        rd_idx_d      = rd_idx_q;
        full_d        = full_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;

        if (flush_now) begin
            col_d = '0;
            row_d = '0;
        end else if (wr_fire) begin
            if (wr_last) begin
                col_d             = '0;
                row_d             = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end else if (col_q == CW'(d - 1)) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        // A release always hits the other bank from a completing write.
        if (bus.ram_rden) begin
            if (rd_last) begin
                rd_idx_d          = '0;
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end else begin
                rd_idx_d = rd_idx_q + 1'b1;
            end
        end

        valid_out_d   = bus.ram_rden || (valid_out_q && !bus.ready_in);
        block_start_d = bus.ram_rden ? (rd_idx_q == '0) : (block_start_q && !bus.ready_in);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q         <= '0;
            row_q         <= '0;
            rd_idx_q      <= '0;
            full_q        <= '0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            valid_out_q   <= 1'b0;
            block_start_q <= 1'b0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            rd_idx_q      <= rd_idx_d;
            full_q        <= full_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            valid_out_q   <= valid_out_d;
            block_start_q <= block_start_d;
        end
    end
endmodule

// File: tb/tb_interleaver_pingpong_ctrl.sv
// Bench for interleaver_pingpong_ctrl: RAM model, queue-driven input, scoreboard
// fed by a permutation model. Define INTLV_FLUSH_EN to include the flush step.
module tb_interleaver_pingpong_ctrl;
    localparam int NCBPS = 192;
    localparam int D     = 16;
    localparam int AW    = $clog2(NCBPS);
    localparam logic [NCBPS-1:0] GOLD_IN  = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;
    localparam logic [NCBPS-1:0] GOLD_OUT = 192'h4B047DFA42F2A5D5F61C021A5851E9A309A24FD58086BD1E;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    interleaver_pingpong_ctrl_if #(.AW(AW)) bus ();
    interleaver_pingpong_ctrl_if #(.AW(AW)) bus4 ();

    interleaver_pingpong_ctrl #(.Ncbps(NCBPS), .Ncpc(2), .d(D)) u_dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    interleaver_pingpong_ctrl #(.Ncbps(NCBPS), .Ncpc(4), .d(D)) u_dut4 (
        .clk(clk), .reset(reset), .bus(bus4)
    );

    // ---------------- RAM model ----------------
    logic mem [0:(1 << (AW + 1)) - 1];
    logic ram_q_r = 1'b0;
    always @(posedge clk) begin
        if (bus.ram_wren) mem[bus.ram_wraddr] <= bus.ram_wdata;
        if (bus.ram_rden) ram_q_r <= mem[bus.ram_rdaddr];
    end
    assign bus.ram_q  = ram_q_r;
    assign bus4.ram_q = 1'b0;

    // ---------------- bench state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [1:0] exp_q[$];      // {data bit, block_start}
    bit in_q[$];
    logic [AW:0] wr_log[$];
    int stall_pct = 0;
    int gap_pct = 0;
    bit hold_stall = 0;
    bit flush_req = 0;
    bit in_fire = 0;
    bit out_fire = 0;
    bit flush_pin;
    int cyc = 0;
    bit mon_stream = 0;
    int ro_drop, vo_first, vo_last, vo_cnt, in_cnt, in_last_cyc;

`ifdef INTLV_FLUSH_EN
    assign flush_pin = bus.flush;
`else
    assign flush_pin = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int jk_of(input int k, input int ncpc);
        int s, col, row, mk;
        s   = ncpc / 2;
        col = k % D;
        row = k / D;
        mk  = (NCBPS / D) * col + row;
        return s * (mk / s) + ((mk + NCBPS - col) % s);
    endfunction

    // blk[NCBPS-1] is the first bit in; output bit i lands at position jk = i
    task automatic push_block(input logic [NCBPS-1:0] blk, input bit use_gold);
        logic out_bits [NCBPS];
        logic [NCBPS-1:0] g;
        g = GOLD_OUT;
        for (int k = 0; k < NCBPS; k++) begin
            in_q.push_back(blk[NCBPS-1-k]);
            out_bits[jk_of(k, 2)] = blk[NCBPS-1-k];
        end
        for (int i = 0; i < NCBPS; i++)
            exp_q.push_back({use_gold ? g[NCBPS-1-i] : out_bits[i], i == 0});
    endtask

    // ---------------- driver tasks ----------------
    always @(posedge clk) begin
        cyc++;
        #1;
        if (in_fire && in_q.size() > 0) void'(in_q.pop_front());
        bus.valid_in = (in_q.size() > 0) && ($urandom_range(0, 99) >= gap_pct);
        bus.data_in  = (in_q.size() > 0) ? in_q[0] : 1'b0;
        bus.ready_in = !hold_stall && ($urandom_range(0, 99) >= stall_pct);
`ifdef INTLV_FLUSH_EN
        bus.flush    = flush_req;
`endif
    end

    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1'b1;
        in_q.delete();
        exp_q.delete();
        @(posedge clk); #2;
        reset = 1'b0;
        wr_log.delete();
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((in_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(in_q.size() + exp_q.size()), 64'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [1:0] e;
        in_fire  = !reset && bus.valid_in && bus.ready_out && !flush_pin;
        out_fire = !reset && bus.valid_out && bus.ready_in;
        if (!reset && bus.ram_wren) wr_log.push_back(bus.ram_wraddr);
        if (mon_stream) begin
            if (in_q.size() > 0 && !bus.ready_out) ro_drop++;
            if (in_fire) begin
                in_cnt++;
                if (in_cnt == NCBPS) in_last_cyc = cyc;
            end
            if (bus.valid_out) begin
                if (vo_first < 0) vo_first = cyc;
                vo_last = cyc;
                vo_cnt++;
            end
        end
        if (out_fire) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("data_out", 64'(bus.data_out), 64'(e[1]));
                chk("block_start", 64'(bus.block_start), 64'(e[0]));
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [NCBPS-1:0] rblk;
        int n;

        bus4.valid_in = 1'b0;
        bus4.data_in  = 1'b0;
        bus4.ready_in = 1'b1;
`ifdef INTLV_FLUSH_EN
        bus4.flush    = 1'b0;
`endif

        // reset state
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        bus4.valid_in = 1'b1;
        @(negedge clk);
        chk("rst_ready_out", 64'(bus.ready_out), 64'd1);
        chk("rst_valid_out", 64'(bus.valid_out), 64'd0);
        chk("rst_block_start", 64'(bus.block_start), 64'd0);
        chk("rst_ram_rden", 64'(bus.ram_rden), 64'd0);

        // Ncpc = 4 address map, every k of the first block
        for (int k = 0; k < NCBPS; k++) begin
            if (k > 0) @(negedge clk);
            chk("ncpc4_wren", 64'(bus4.ram_wren), 64'd1);
            chk("ncpc4_wraddr", 64'(bus4.ram_wraddr), 64'(jk_of(k, 4)));
        end
        @(posedge clk); #2;
        bus4.valid_in = 1'b0;

        // golden block and Ncpc = 2 address spot checks
        do_reset();
        push_block(GOLD_IN, 1'b1);
        wait_drain("golden_drain", 1000);
        chk("wr_log_size", 64'(wr_log.size()), 64'(NCBPS));
        if (wr_log.size() >= NCBPS) begin
            chk("jk_k0", 64'(wr_log[0]), 64'd0);
            chk("jk_k1", 64'(wr_log[1]), 64'd12);
            chk("jk_k15", 64'(wr_log[15]), 64'd180);
            chk("jk_k16", 64'(wr_log[16]), 64'd1);
            chk("jk_k191", 64'(wr_log[191]), 64'd191);
        end

        // five blocks back to back
        do_reset();
        ro_drop = 0; vo_first = -1; vo_last = -1; vo_cnt = 0; in_cnt = 0; in_last_cyc = -1;
        mon_stream = 1'b1;
        for (int b = 0; b < 5; b++) push_block(GOLD_IN, 1'b1);
        wait_drain("stream_drain", 2000);
        mon_stream = 1'b0;
        chk("stream_ready_drop", 64'(ro_drop), 64'd0);
        chk("stream_valid_cycles", 64'(vo_cnt), 64'(5 * NCBPS));
        chk("stream_valid_span", 64'(vo_last - vo_first + 1), 64'(5 * NCBPS));
        // valid_out rises on the edge after the first read issue
        chk("first_out_latency", 64'(vo_first - in_last_cyc), 64'd2);

        // long stall mid-block
        do_reset();
        for (int b = 0; b < 3; b++) push_block(GOLD_IN, 1'b1);
        n = 0;
        while (exp_q.size() > 3 * NCBPS - 96 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("bp_reach_mid", 64'(exp_q.size() <= 3 * NCBPS - 96), 64'd1);
        hold_stall = 1'b1;
        repeat (300) @(negedge clk);
        chk("bp_valid_hold", 64'(bus.valid_out), 64'd1);
        if (exp_q.size() > 0) begin
            chk("bp_data_hold", 64'(bus.data_out), 64'(exp_q[0][1]));
            chk("bp_bs_hold", 64'(bus.block_start), 64'(exp_q[0][0]));
        end
        chk("bp_ready_out_low", 64'(bus.ready_out), 64'd0);
        chk("bp_rden_low", 64'(bus.ram_rden), 64'd0);
        hold_stall = 1'b0;
        wait_drain("bp_drain", 2000);

        // reset after about 100 input bits
        do_reset();
        push_block(GOLD_IN, 1'b1);
        n = 0;
        while (in_q.size() > NCBPS - 100 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #2;
        reset = 1'b1;
        in_q.delete();
        exp_q.delete();
        @(negedge clk);
        chk("midrst_wren", 64'(bus.ram_wren), 64'd0);
        chk("midrst_rden", 64'(bus.ram_rden), 64'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_ready_out", 64'(bus.ready_out), 64'd1);
        chk("midrst_valid_out", 64'(bus.valid_out), 64'd0);
        push_block(GOLD_IN, 1'b1);
        wait_drain("midrst_drain", 1000);

        // random blocks with input gaps and output stalls
        do_reset();
        gap_pct = 30;
        stall_pct = 40;
        for (int b = 0; b < 4; b++) begin
            for (int w = 0; w < 6; w++) rblk = {rblk[NCBPS-33:0], 32'($urandom())};
            push_block(rblk, 1'b0);
        end
        wait_drain("random_drain", 6000);
        gap_pct = 0;
        stall_pct = 0;

`ifdef INTLV_FLUSH_EN
        // 50 bits, one flush cycle, then the golden block
        do_reset();
        for (int i = 0; i < 50; i++) in_q.push_back(1'($urandom_range(0, 1)));
        n = 0;
        while (in_q.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #2;
        flush_req = 1'b1;
        push_block(GOLD_IN, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("flush_valid_in", 64'(bus.valid_in), 64'd1);
        chk("flush_wren", 64'(bus.ram_wren), 64'd0);
        flush_req = 1'b0;
        wait_drain("flush_drain", 1000);
`endif

        // quiet tail catches stray outputs
        repeat (50) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
